// File: rtl/scan_pkg.sv
// Shared types and constants for the h/k raster scan sequencer.
package scan_pkg;

  localparam int unsigned SCAN_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_axis_cnt.sv
// Loadable W-bit up/down axis counter with an equality end-of-axis compare.
module scan_axis_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         down,
  input  logic [W-1:0] end_val,
  output logic [W-1:0] cnt,
  output logic         at_end
);

  // Counter register: load has priority over step; counting wraps modulo 2^W.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (step) begin
      cnt <= down ? cnt - W'(1) : cnt + W'(1);
    end
  end

  assign at_end = (cnt == end_val);

endmodule

// File: rtl/scan_ctrl.sv
// Two-axis h/k scan sequencer with valid/ready output handshake.
// Optional build macro: SCAN_SERPENTINE_EN selects boustrophedon order
// (odd rows count h downwards); undefined gives plain raster order.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned W = SCAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] h_last,
  input  logic [W-1:0] k_last,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] h,
  output logic [W-1:0] k,
  output logic         last,
  output logic         busy,
  output logic         done
);

  scan_state_t  state;
  logic [W-1:0] h_last_q;
  logic [W-1:0] k_last_q;
  logic [W-1:0] h_end_val;
  logic         h_load, h_step, h_down, h_end;
  logic         k_load, k_step, k_end;
  logic         xfer;

`ifdef SCAN_SERPENTINE_EN
  assign h_down = k[0];
`else
  assign h_down = 1'b0;
`endif

  // Row end is the far limit on upward rows and zero on downward rows.
  assign h_end_val = h_down ? '0 : h_last_q;
  assign xfer      = out_valid && out_ready;
  assign last      = out_valid && h_end && k_end;

  // Counter control: clear both axes on an accepted start, then advance per beat.
  always_comb begin
    h_load = 1'b0;
    h_step = 1'b0;
    k_load = 1'b0;
    k_step = 1'b0;
    if (state == IDLE) begin
      if (start && !abort) begin
        h_load = 1'b1;
        k_load = 1'b1;
      end
    end else if (state == RUN && !abort && xfer) begin
      if (!h_end) begin
        h_step = 1'b1;
      end else if (!k_end) begin
        k_step = 1'b1;
`ifndef SCAN_SERPENTINE_EN
        h_load = 1'b1;
`endif
      end
    end
  end

  // Sequencer FSM with registered handshake/status outputs and latched limits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      h_last_q  <= '0;
      k_last_q  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            h_last_q  <= h_last;
            k_last_q  <= k_last;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (xfer && h_end && k_end) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  scan_axis_cnt #(.W(W)) u_h_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (h_load),
    .load_val ('0),
    .step     (h_step),
    .down     (h_down),
    .end_val  (h_end_val),
    .cnt      (h),
    .at_end   (h_end)
  );

  scan_axis_cnt #(.W(W)) u_k_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (k_load),
    .load_val ('0),
    .step     (k_step),
    .down     (1'b0),
    .end_val  (k_last_q),
    .cnt      (k),
    .at_end   (k_end)
  );

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl: vector table plus multi-cycle sequences.
module tb_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, out_ready;
  logic [3:0] h_last, k_last;
  logic       out_valid, last, busy, done;
  logic [3:0] h, k;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst, start, abort, rdy;
    logic [3:0] hl, kl;
    logic       e_valid, e_busy, e_done, e_last, chk_hk;
    logic [3:0] e_h, e_k;
  } vec_t;

  vec_t tbl[$];

  scan_ctrl #(.W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .h_last    (h_last),
    .k_last    (k_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .h         (h),
    .k         (k),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic r, logic s, logic a, logic rd, int hl, int kl,
                              logic ev, logic eb, logic ed, logic el, logic ch, int eh, int ek);
    vec_t v;
    v.rst = r; v.start = s; v.abort = a; v.rdy = rd;
    v.hl = 4'(hl); v.kl = 4'(kl);
    v.e_valid = ev; v.e_busy = eb; v.e_done = ed; v.e_last = el; v.chk_hk = ch;
    v.e_h = 4'(eh); v.e_k = 4'(ek);
    return v;
  endfunction

  // Reference scan order: beat b of a grid with h limit hl.
  function automatic logic [3:0] ref_h(int b, int hl);
    int r;
    int row;
    r   = b % (hl + 1);
    row = b / (hl + 1);
`ifdef SCAN_SERPENTINE_EN
    if (row % 2 == 1) return 4'(hl - r);
`endif
    if (row < 0) return 4'(0);
    return 4'(r);
  endfunction

  function automatic logic [3:0] ref_k(int b, int hl);
    return 4'(b / (hl + 1));
  endfunction

  // Full scan with ready always high (mode 0) or toggling 1/0 (mode 1).
  task automatic run_scan(input int hl, input int kl, input int mode);
    int total;
    int beats;
    int cyc;
    total = (hl + 1) * (kl + 1);
    beats = 0;
    cyc   = 0;
    start = 1'b1; h_last = 4'(hl); k_last = 4'(kl); out_ready = 1'b0;
    tick();
    start = 1'b0; h_last = ~4'(hl); k_last = ~4'(kl);
    while (beats < total && cyc < 2000) begin
      out_ready = (mode == 1) ? ~cyc[0] : 1'b1;
      check("scan_valid", out_valid, 1);
      check("scan_busy", busy, 1);
      check("scan_h", h, ref_h(beats, hl));
      check("scan_k", k, ref_k(beats, hl));
      check("scan_last", last, (beats == total - 1) ? 1 : 0);
      tick();
      if (out_ready) beats++;
      cyc++;
    end
    check("scan_beats", beats, total);
    check("end_done", done, 1);
    check("end_valid", out_valid, 0);
    check("end_busy", busy, 0);
    out_ready = 1'b1;
    tick();
    check("post_done", done, 0);
    check("post_valid", out_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    h_last = '0; k_last = '0;

    // Basic 4x2 scan, then idle and start+abort behaviour.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 3, 1, 1, 1, 0, 0, 1, 0, 0));
    for (int b = 1; b < 8; b++)
      tbl.push_back(mk(0, 0, 0, 1, 7, 7, 1, 1, 0, (b == 7), 1, ref_h(b, 3), ref_k(b, 3)));
    tbl.push_back(mk(0, 0, 0, 1, 7, 7, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
      out_ready = tbl[i].rdy; h_last = tbl[i].hl; k_last = tbl[i].kl;
      tick();
      check($sformatf("v%0d_valid", i), out_valid, tbl[i].e_valid);
      check($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      check($sformatf("v%0d_done", i), done, tbl[i].e_done);
      check($sformatf("v%0d_last", i), last, tbl[i].e_last);
      if (tbl[i].chk_hk) begin
        check($sformatf("v%0d_h", i), h, tbl[i].e_h);
        check($sformatf("v%0d_k", i), k, tbl[i].e_k);
      end
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;

    // Degenerate 1x1 grid, start ignored in DONE, restart in the following cycle.
    start = 1'b1; h_last = 4'd0; k_last = 4'd0; out_ready = 1'b1;
    tick();
    check("deg_valid", out_valid, 1);
    check("deg_last", last, 1);
    check("deg_h", h, 0);
    check("deg_k", k, 0);
    tick();
    check("deg_done", done, 1);
    check("deg_done_valid", out_valid, 0);
    tick();
    check("done_ignores_start", out_valid, 0);
    check("done_one_cycle", done, 0);
    tick();
    check("restart_valid", out_valid, 1);
    check("restart_h", h, 0);
    start = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("restart_abort_valid", out_valid, 0);

    // Abort while the fifth coordinate of a 4x4 scan is handshaking.
    start = 1'b1; h_last = 4'd3; k_last = 4'd3; out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_pre_h", h, 0);
    check("abort_pre_k", k, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tick();
    check("abort_no_done", done, 0);
    check("abort_idle", busy, 0);

    // Reset in the middle of a scan.
    start = 1'b1; h_last = 4'd2; k_last = 4'd2;
    tick();
    start = 1'b0;
    tick(); tick();
    check("pre_rst_h", h, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_last", last, 0);
    check("rst_h", h, 0);
    check("rst_k", k, 0);
    tick();
    check("rst_no_done", done, 0);

    // Multi-cycle scans: backpressure, full range, direction order.
    run_scan(2, 2, 1);
    run_scan(15, 15, 0);
    run_scan(2, 2, 0);
    run_scan(3, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
